// File: rtl/md_unit_if.sv
// Issue/readback bundle between the Execute stage and md_unit.
// Handshake: an op on `op` is accepted in exactly the cycle `start` is high; while `busy` is high, ops are ignored.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             dbg_state;

    modport master (output req, op, rs, rt, input start, busy, rd_data, dbg_state);
    modport slave  (input req, op, rs, rt, output start, busy, rd_data, dbg_state);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mfhi/mflo/mthi/mtlo.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when MD_MADD_EN is defined.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3, OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MFHI  = 4'd7, OP_MFLO  = 4'd8;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11, OP_MSUBU = 4'd12;
`endif

    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_phi, r_plo;

    logic signed [2*WIDTH-1:0] w_sprod;
    logic        [2*WIDTH-1:0] w_uprod;
    logic        [WIDTH-1:0]   w_div_b;
    logic signed [WIDTH-1:0]   w_sq, w_sr;
    logic                      w_class;
    logic [CW-1:0]             w_lat;
    logic [WIDTH-1:0]          w_nhi, w_nlo;
    logic                      w_start;

    assign w_sprod = $signed(bus.rs) * $signed(bus.rt);
    assign w_uprod = bus.rs * bus.rt;

    // MIN/-1 is steered to MIN/1, which yields exactly the required LO=MIN, HI=0 without overflow.
    assign w_div_b = (bus.rs == MIN_S && bus.rt == '1) ? WIDTH'(1) : bus.rt;
    assign w_sq    = $signed(bus.rs) / $signed(w_div_b);
    assign w_sr    = $signed(bus.rs) % $signed(w_div_b);

    always_comb begin
        w_class = 1'b0;
        w_lat   = '0;
        w_nhi   = r_hi;
        w_nlo   = r_lo;
        case (bus.op)
            OP_MULT: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = w_sprod;
            end
            OP_MULTU: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = w_uprod;
            end
            OP_DIV: begin
                w_class = 1'b1;
                w_lat   = CW'(DIV_CYCLES);
                if (bus.rt != '0) begin
                    w_nlo = w_sq;
                    w_nhi = w_sr;
                end
            end
            OP_DIVU: begin
                w_class = 1'b1;
                w_lat   = CW'(DIV_CYCLES);
                if (bus.rt != '0) begin
                    w_nlo = bus.rs / bus.rt;
                    w_nhi = bus.rs % bus.rt;
                end
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = {r_hi, r_lo} + w_sprod;
            end
            OP_MADDU: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = {r_hi, r_lo} + w_uprod;
            end
            OP_MSUB: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = {r_hi, r_lo} - w_sprod;
            end
            OP_MSUBU: begin
                w_class        = 1'b1;
                w_lat          = CW'(MULT_CYCLES);
                {w_nhi, w_nlo} = {r_hi, r_lo} - w_uprod;
            end
`endif
            default: ;
        endcase
    end

    // Reset is folded in so that start stays low for any op while reset is held.
    assign w_start       = w_class && (r_state == S_IDLE) && !bus.req && !reset;
    assign bus.start     = w_start;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.dbg_state = r_state;
    assign bus.rd_data   = (bus.op == OP_MFHI) ? r_hi :
                           (bus.op == OP_MFLO) ? r_lo : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_phi   <= w_nhi;
                        r_plo   <= w_nlo;
                        r_cnt   <= w_lat;
                        r_state <= S_RUN;
                    end else if (!bus.req) begin
                        if (bus.op == OP_MTHI) r_hi <= bus.rs;
                        if (bus.op == OP_MTLO) r_lo <= bus.rs;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= r_phi;
                        r_lo    <= r_plo;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the Execute stage of the pipelined MIPS core. It accepts one multiply or divide operation at a time and holds it for a configurable latency. It commits the 2×WIDTH result into HI/LO and serves mfhi/mflo/mthi/mtlo. The `start` and `busy` outputs drive the hazard unit's stall logic. The `req` input suppresses every architectural side effect in the cycle an exception or interrupt is taken.

## Interface
Parameters:
- WIDTH, 32: operand, HI and LO width.
- MULT_CYCLES, 5: busy cycles for the multiply class; must be ≥1.
- DIV_CYCLES, 10: busy cycles for the divide class; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  exception/interrupt request; blocks issue and mthi/mtlo writes this cycle.
- op  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13–15 are NOP.
- rs  in  WIDTH  operand A, already forwarded.
- rt  in  WIDTH  operand B, already forwarded.
- start  out  1  combinational; high in the cycle an op is accepted.
- busy  out  1  registered; high while an accepted op is running.
- rd_data  out  WIDTH  combinational; HI when op=MFHI, LO when op=MFLO, otherwise 0.

## Operation
- State machine with two states, IDLE and RUN. The counter is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits wide.
- Issue:
  - Condition: op is in the mult/div/acc class, state is IDLE, and req=0.
  - Response: start=1. The full result is computed combinationally from rs/rt (and HI/LO for accumulate ops) and latched into pending_hi/pending_lo. The counter loads the class latency and the state goes to RUN.
- RUN:
  - The counter decrements every cycle.
  - When the counter is 1, the next edge writes pending_hi/pending_lo into HI/LO and returns the state to IDLE.
  - busy = (state == RUN).
- An op presented while busy=1 is ignored: start=0 and nothing is latched. Holding the op is the stall logic's job.
- MULT/MULTU: signed or unsigned WIDTH×WIDTH multiply → {HI,LO}.
- DIV/DIVU:
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - MIN/−1 gives LO=MIN, HI=0.
  - Divisor 0: the op still issues and runs its full latency; HI/LO keep their old values.
- MADD*/MSUB*: {HI,LO} ± signed/unsigned rs×rt, wrapping mod 2^(2·WIDTH). Uses MULT_CYCLES.
- MTHI/MTLO write rs into HI/LO at the edge, only when busy=0 and req=0.
- MFHI/MFLO read the current registers. While busy=1 they return the pre-op values.
- req=1 during RUN has no effect: the in-flight op completes.

## Timing
- Reset: state=IDLE, counter=0, HI=LO=0, pending registers=0. Outputs: busy=0, start=0 (for any op while reset is held), rd_data=0.
- Reset mid-RUN: takes effect immediately and asynchronously. The pending result is discarded.
- Latency:
  - Issue edge at cycle T.
  - busy=1 in cycles T+1 … T+N, where N is the class latency.
  - HI/LO hold the new value from cycle T+N+1, in the same cycle busy drops.
- Back-to-back issue: the earliest next start is cycle T+N+1.
- MTHI/MTLO in cycle T+N+1 overwrite the freshly committed value; this is legal.
- start and busy are never high in the same cycle.

## Configuration
- MD_MADD_EN defined: ops 9–12 are decoded and use MULT_CYCLES.
- MD_MADD_EN undefined: ops 9–12 are NOP (start=0, no state change), and the accumulate adder is not synthesised.

## Test plan
- Reset: assert reset with op=MFHI → rd_data=0 and busy=0; after release, MFLO → 0.
- MULT with rs=0xFFFFFFFD, rt=7 → start=1 for 1 cycle, busy=1 for exactly 5 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB.
- Divides:
  - DIVU 100/7 → busy 10 cycles, then LO=14, HI=2.
  - DIV 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU x/0 → HI/LO unchanged.
- req blocking:
  - MULT with req=1 → start=0, busy stays 0, HI/LO unchanged.
  - MTHI 0x1234 with req=1 → HI unchanged.
  - Same MTHI with req=0 → HI=0x1234.
- Reset mid-op: reset asserted in the 3rd busy cycle of a DIV → busy=0 within the same cycle, HI=LO=0, and a new MULT issues after release.
- Accumulate:
  - MD_MADD_EN on: HI:LO=0:0x10, MADD rs=2, rt=3 → LO=0x16, HI=0.
  - MD_MADD_EN on: MSUBU with HI:LO=0, rs=1, rt=1 → HI=LO=0xFFFFFFFF.
  - MD_MADD_EN off: op 9 → start=0.
